bit_scan_32: RTL and testbench
==============================

# bit_scan_32

Iterative set-bit enumerator for 32-bit datapath words. Accepts one word over a valid/ready handshake and emits the index of every set bit as a stream, one index per cycle, ending with a `last` flag. An all-zero word produces a single beat flagged `out_zero`. It is the expanding counterpart of the 32-bit zero detector and serves multi-register/bit-mask consumers in the CPU datapath, such as register-list sequencing and interrupt-pending scans.

## Interface
- `MSB_FIRST`, default 0: 0 emits indices ascending (bit 0 first); 1 emits them descending (bit 31 first).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a word.
- `in_data` in 32: word to scan.
- `out_valid` out 1: `out_idx`, `out_last`, `out_zero` and `out_cnt` are valid.
- `out_ready` in 1: consumer accepts the current beat.
- `out_idx` out 5: index of the current set bit.
- `out_last` out 1: current beat is the final beat for this word.
- `out_zero` out 1: the accepted word was 0x00000000.
- `out_cnt` out 5: ordinal of the current beat within the word, starting at 0.
- `busy` out 1: a word is held, in states ZERO or SCAN.

## Operation
- States: IDLE, SCAN, ZERO. Encoding is free.
- In IDLE:
  - `in_ready` = 1.
  - An input handshake (`in_valid && in_ready`) loads `mask <= in_data` and `cnt <= 0`.
  - Next state is ZERO if `in_data == 0`, otherwise SCAN.
- In SCAN:
  - `out_valid` = 1.
  - `out_idx` is the lowest set bit of `mask` (highest set bit if `MSB_FIRST` = 1).
  - `out_last` = 1 when exactly one bit of `mask` is set.
  - `out_zero` = 0.
  - On an output handshake (`out_valid && out_ready`), the emitted bit is cleared in `mask` and `cnt` increments.
  - If `out_last` = 1 on that handshake, the next state is IDLE.
- In ZERO:
  - `out_valid` = 1, `out_idx` = 0, `out_last` = 1, `out_zero` = 1, `out_cnt` = 0.
  - On a handshake, the next state is IDLE.
- `out_cnt` = `cnt`.
  - A full word of 32 beats emits `out_cnt` values 0..31.
  - `cnt` is 5 bits wide and never needs to represent 32.
- `in_ready` = 0 in SCAN and ZERO. `in_valid` is ignored there, and no word is buffered.
- `mask` and `cnt` change only on an output handshake. All `out_*` signals are therefore held stable while `out_valid && !out_ready`.
- The priority encoder is purely combinational from `mask`. No scan cycles are spent on zero bits.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state = IDLE, `mask` = 0, `cnt` = 0.
  - `out_valid` = 0, `out_idx` = 0, `out_last` = 0, `out_zero` = 0, `out_cnt` = 0, `busy` = 0, `in_ready` = 1.
- Input handshake at edge N: the first `out_valid` is high in cycle N+1. Latency is 1 cycle.
- Throughput: 1 index per cycle while `out_ready` = 1.
  - A word with k set bits occupies k cycles of output. An all-zero word occupies 1 cycle.
- After the handshake of the `out_last` beat, `in_ready` = 1 in the next cycle.
  - The minimum spacing between accepted words is k+1 cycles.
- If `out_ready` is held low indefinitely, the output beat is held with no loss.
- Reset mid-word: the word is dropped immediately, `out_valid` falls asynchronously, and no further beats are emitted after `rst_n` rises.
- `in_valid` asserted during reset is not accepted. The first possible acceptance is the first rising edge with `rst_n` high.

## Test plan
- Zero word: accept 0x00000000 → one beat with `out_zero` = 1, `out_last` = 1, `out_idx` = 0, `out_cnt` = 0; `in_ready` = 1 on the following cycle.
- Sparse word, `MSB_FIRST` = 0, `out_ready` tied high: accept 0x80000001 at N → beat (idx 0, cnt 0, last 0) at N+1, then (idx 31, cnt 1, last 1) at N+2; `in_ready` = 1 at N+3.
- Full word: 0xFFFFFFFF → 32 consecutive beats with idx 0..31 and cnt 0..31; `out_last` = 1 only on idx 31; `busy` is high for 32 cycles.
- Backpressure: 0x00000110 with `out_ready` low for 3 cycles → idx 4 held stable for 4 cycles, then idx 8 with last 1; `in_valid` pulses during the scan are not accepted.
- Order parameter: `MSB_FIRST` = 1, word 0x00000110 → idx 8 (cnt 0), then idx 4 (cnt 1, last 1).
- Reset mid-scan: accept 0x000000F0, take one beat (idx 4), then drive `rst_n` low → `out_valid` = 0 immediately and `in_ready` = 1; after `rst_n` rises, no beats appear until a new word 0x00000002 is accepted, which yields idx 1 with last 1.

Source files
------------

// File: rtl/bit_scan_32.sv
// Iterative set-bit enumerator: accepts a 32-bit word and streams the index
// of each set bit, one per cycle, with a last flag; a zero word yields one beat.
module bit_scan_32 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [4:0]  out_idx_o,
  output logic        out_last_o,
  output logic        out_zero_o,
  output logic [4:0]  out_cnt_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mask_q, mask_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [4:0]  scan_idx;
  logic        one_bit;

  // Priority encoder: the last match in loop order wins, so the loop runs
  // towards the bit that must have priority.
  always_comb begin
    scan_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (MSB_FIRST) begin
        if (mask_q[i]) scan_idx = 5'(i);
      end else begin
        if (mask_q[31-i]) scan_idx = 5'(31 - i);
      end
    end
  end

  assign one_bit = (mask_q != 32'd0) && ((mask_q & (mask_q - 32'd1)) == 32'd0);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          mask_d  = in_data_i;
          cnt_d   = 5'd0;
          state_d = (in_data_i == 32'd0) ? ZERO : SCAN;
        end
      end
      SCAN: begin
        if (out_ready_i) begin
          mask_d = mask_q & ~(32'd1 << scan_idx);
          cnt_d  = cnt_q + 5'd1;
          if (one_bit) state_d = IDLE;
        end
      end
      ZERO: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= 32'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only, so they drop with the async reset.
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q != IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_idx_o   = (state_q == SCAN) ? scan_idx : 5'd0;
  assign out_last_o  = (state_q == ZERO) || ((state_q == SCAN) && one_bit);
  assign out_zero_o  = (state_q == ZERO);
  assign out_cnt_o   = cnt_q;

endmodule

// File: tb/tb_bit_scan_32.sv
// Self-checking bench for bit_scan_32: runs an LSB-first and an MSB-first
// instance side by side on the same stimulus.
module tb_bit_scan_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_last, a_zero, a_busy;
  logic [4:0]  a_idx, a_cnt;
  logic        m_in_ready, m_out_valid, m_last, m_zero, m_busy;
  logic [4:0]  m_idx, m_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bit_scan_32 #(.MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .out_idx_o(a_idx), .out_last_o(a_last), .out_zero_o(a_zero),
    .out_cnt_o(a_cnt), .busy_o(a_busy)
  );

  bit_scan_32 #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(m_in_ready), .in_data_i(in_data),
    .out_valid_o(m_out_valid), .out_ready_i(out_ready),
    .out_idx_o(m_idx), .out_last_o(m_last), .out_zero_o(m_zero),
    .out_cnt_o(m_cnt), .busy_o(m_busy)
  );

  typedef struct {
    logic [31:0] data;
    int          n;       // expected number of beats
    logic [4:0]  lo_idx;  // lowest set bit (first beat LSB-first)
    logic [4:0]  hi_idx;  // highest set bit (first beat MSB-first)
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accept one word with out_ready high and walk all of its beats.
  task automatic run_word(input vec_t v);
    int         got;
    int         prev;
    bit         fin;
    logic [4:0] first_a, last_a, first_m, last_m;
    first_a = '0; last_a = '0; first_m = '0; last_m = '0;
    @(negedge clk);
    check("in_ready_before", a_in_ready, 1);
    in_valid  = 1'b1;
    in_data   = v.data;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_valid", a_out_valid, 1);
    got = 0; prev = -1; fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      if (!a_out_valid) begin
        check("beat_valid", a_out_valid, 1);
        fin = 1'b1;
      end else begin
        if (got == 0) begin
          first_a = a_idx;
          first_m = m_idx;
        end
        last_a = a_idx;
        last_m = m_idx;
        check("cnt", a_cnt, 32'(got));
        check("cnt_m", m_cnt, 32'(got));
        check("zero", a_zero, v.data == 32'd0);
        check("last", a_last, got == v.n - 1);
        check("last_m", m_last, got == v.n - 1);
        check("busy", a_busy, 1);
        check("in_ready_busy", a_in_ready, 0);
        if (v.data != 32'd0) begin
          check("idx_set", v.data[a_idx], 1);
          check("idx_ascending", int'(a_idx) > prev, 1);
        end
        prev = int'(a_idx);
        if (a_last) fin = 1'b1;
        got++;
        @(negedge clk);
      end
    end
    check("beat_count", 32'(got), 32'(v.n));
    check("first_idx", first_a, v.lo_idx);
    check("last_idx", last_a, v.hi_idx);
    check("first_idx_m", first_m, v.hi_idx);
    check("last_idx_m", last_m, v.lo_idx);
    check("in_ready_after", a_in_ready, 1);
    check("valid_after", a_out_valid, 0);
    check("busy_after", a_busy, 0);
  endtask

  initial begin
    vec_t v2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;

    vecs[0] = '{32'h0000_0000, 1,  5'd0,  5'd0};
    vecs[1] = '{32'h8000_0001, 2,  5'd0,  5'd31};
    vecs[2] = '{32'h0000_0110, 2,  5'd4,  5'd8};
    vecs[3] = '{32'hFFFF_FFFF, 32, 5'd0,  5'd31};
    vecs[4] = '{32'h0000_0001, 1,  5'd0,  5'd0};
    vecs[5] = '{32'h8000_0000, 1,  5'd31, 5'd31};
    vecs[6] = '{32'hA500_0000, 4,  5'd24, 5'd31};
    vecs[7] = '{32'h0001_0000, 1,  5'd16, 5'd16};

    // Reset state, with in_valid asserted to show it is ignored.
    in_valid = 1'b1;
    in_data  = 32'h0000_0003;
    repeat (2) @(negedge clk);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_idx", a_idx, 0);
    check("rst_out_last", a_last, 0);
    check("rst_out_zero", a_zero, 0);
    check("rst_out_cnt", a_cnt, 0);
    check("rst_busy", a_busy, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("post_rst_valid", a_out_valid, 0);

    for (int i = 0; i < 8; i++) run_word(vecs[i]);

    // Backpressure: 0x110 held for 4 cycles, in_valid pulsed during the scan.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'h0000_0110;
    out_ready = 1'b0;
    @(negedge clk);
    in_data = 32'h0000_0001;
    for (int c = 0; c < 4; c++) begin
      check("bp_valid", a_out_valid, 1);
      check("bp_idx", a_idx, 4);
      check("bp_idx_m", m_idx, 8);
      check("bp_last", a_last, 0);
      check("bp_cnt", a_cnt, 0);
      check("bp_in_ready", a_in_ready, 0);
      if (c == 3) begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      @(negedge clk);
    end
    check("bp2_idx", a_idx, 8);
    check("bp2_idx_m", m_idx, 4);
    check("bp2_last", a_last, 1);
    check("bp2_last_m", m_last, 1);
    check("bp2_cnt", a_cnt, 1);
    @(negedge clk);
    check("bp_done_ready", a_in_ready, 1);
    check("bp_no_buffered", a_out_valid, 0);

    // Reset mid-scan of 0xF0 after one beat has been taken.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0000_00F0;
    @(negedge clk);
    in_valid = 1'b0;
    check("rs_idx0", a_idx, 4);
    @(negedge clk);
    check("rs_idx1", a_idx, 5);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0000_0008;
    #1;
    check("rs_async_valid", a_out_valid, 0);
    check("rs_async_ready", a_in_ready, 1);
    check("rs_async_busy", a_busy, 0);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rs_quiet", a_out_valid, 0);
    end
    v2 = '{32'h0000_0002, 1, 5'd1, 5'd1};
    run_word(v2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
